jericalla_fetch: RTL and testbench

Instruction fetch/sequencer stage sitting directly upstream of the `Jericalla_Evolution` datapath. It holds a small writable program memory of 17-bit Jericalla instructions (op[16:15], rs1[14:10], rs2[9:5], rd[4:0]). On command it streams a program of programmable length, one instruction per clock, into the datapath's `instruction` input. Stall cycles and idle cycles are filled with the all-zero NOP.

---
 rtl/jericalla_fetch.sv | 117 +++++++++++
 tb/tb_jericalla_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jericalla_fetch.sv
// jericalla_fetch: instruction fetch/sequencer for the Jericalla datapath.
// Holds a writable program memory and streams a programmable-length program
// one instruction per clock. Stalled and idle cycles carry the all-zero NOP.
module jericalla_fetch #(
  parameter int IW    = 17,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WE,
  input  logic [AW-1:0] WADDR,
  input  logic [IW-1:0] WDATA,
  input  logic          START,
  input  logic [AW:0]   LEN,
  input  logic          STALL,
  output logic [IW-1:0] INSTR,
  output logic          VALID,
  output logic [AW-1:0] PC,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  // Requested lengths beyond the memory size issue the whole memory once.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    return (l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  logic [IW-1:0] mem [DEPTH];

  state_t        state;
  logic [AW:0]   len_q;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] pc_q;
  logic [IW-1:0] instr_p0;
  logic          vld_p0;
  logic          busy_q;
  logic          done_q;

  // Program memory: writable only while the sequencer is idle; not reset.
  always_ff @(posedge CLK) begin
    if (WE && (state == IDLE)) begin
      mem[WADDR] <= WDATA;
    end
  end

  // Sequencer FSM with registered instruction, valid and status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      pc_q     <= '0;
      instr_p0 <= '0;
      vld_p0   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          instr_p0 <= '0;
          vld_p0   <= 1'b0;
          if (START) begin
            len_q  <= clamp_len(LEN);
            pc_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            state  <= (clamp_len(LEN) == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          if (STALL) begin
            instr_p0 <= '0;
            vld_p0   <= 1'b0;
          end else begin
            // Issue stage: mem[PC] becomes the datapath instruction next cycle.
            instr_p0 <= mem[pc_q];
            vld_p0   <= 1'b1;
            pc_q     <= pc_q + PC_ONE;
            cnt_q    <= cnt_q + CNT_ONE;
            if ((cnt_q + CNT_ONE) == len_q) begin
              state <= FIN;
            end
          end
        end
        FIN: begin
          instr_p0 <= '0;
          vld_p0   <= 1'b0;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign INSTR = instr_p0;
  assign VALID = vld_p0;
  assign PC    = pc_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_jericalla_fetch.sv
// tb_jericalla_fetch: directed self-checking bench for jericalla_fetch.
module tb_jericalla_fetch;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WE = 1'b0;
  logic [4:0]  WADDR = '0;
  logic [16:0] WDATA = '0;
  logic        START = 1'b0;
  logic [5:0]  LEN = '0;
  logic        STALL = 1'b0;
  logic [16:0] INSTR;
  logic        VALID;
  logic [4:0]  PC;
  logic        BUSY;
  logic        DONE;

  int tests = 0;
  int fails = 0;

  logic [16:0] prog [6];

  jericalla_fetch #(.IW(17), .DEPTH(32), .AW(5)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .START(START), .LEN(LEN), .STALL(STALL), .INSTR(INSTR), .VALID(VALID),
    .PC(PC), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // One rising edge, then settle so outputs can be sampled and inputs changed.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [16:0] fill_word(input int a);
    return (a < 6) ? prog[a] : 17'(32'h100 + a);
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    tests++; if (INSTR !== 17'h0) begin fails++; $display("FAIL reset_instr got %h want %h", INSTR, 17'h0); end
    tests++; if (VALID !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", VALID); end
    tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", BUSY); end
    tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", DONE); end
    tests++; if (PC !== 5'd0) begin fails++; $display("FAIL reset_pc got %0d want 0", PC); end
  endtask

  task automatic load_memory();
    for (int a = 0; a < 32; a++) begin
      WE = 1'b1; WADDR = 5'(a); WDATA = fill_word(a);
      step();
    end
    WE = 1'b0;
  endtask

  task automatic test_stream();
    START = 1'b1; LEN = 6'd6;
    step();
    START = 1'b0;
    tests++; if (BUSY !== 1'b1 || VALID !== 1'b0) begin fails++; $display("FAIL stream_e0 got busy=%b valid=%b want busy=1 valid=0", BUSY, VALID); end
    for (int i = 0; i < 6; i++) begin
      step();
      tests++; if (VALID !== 1'b1 || INSTR !== prog[i]) begin fails++; $display("FAIL stream_w%0d got valid=%b instr=%h want valid=1 instr=%h", i, VALID, INSTR, prog[i]); end
      tests++; if (PC !== 5'(i + 1) || DONE !== 1'b0) begin fails++; $display("FAIL stream_pc%0d got pc=%0d done=%b want pc=%0d done=0", i, PC, DONE, i + 1); end
    end
    step();
    tests++; if (DONE !== 1'b1 || VALID !== 1'b0 || INSTR !== 17'h0) begin fails++; $display("FAIL stream_done got done=%b valid=%b instr=%h want 1 0 0", DONE, VALID, INSTR); end
    tests++; if (BUSY !== 1'b0 || PC !== 5'd6) begin fails++; $display("FAIL stream_end got busy=%b pc=%0d want busy=0 pc=6", BUSY, PC); end
    step();
    tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL stream_done_pulse got %b want 0", DONE); end
  endtask

  task automatic test_stall();
    int k;
    k = 0;
    START = 1'b1; LEN = 6'd6;
    step();
    START = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      STALL = (c == 2 || c == 3);
      step();
      if (c == 2 || c == 3) begin
        tests++; if (VALID !== 1'b0 || INSTR !== 17'h0 || PC !== 5'(k)) begin fails++; $display("FAIL stall_bubble%0d got valid=%b instr=%h pc=%0d want 0 0 %0d", c, VALID, INSTR, PC, k); end
      end else begin
        tests++; if (VALID !== 1'b1 || INSTR !== prog[k] || PC !== 5'(k + 1)) begin fails++; $display("FAIL stall_word%0d got valid=%b instr=%h pc=%0d want 1 %h %0d", c, VALID, INSTR, PC, prog[k], k + 1); end
        k++;
      end
      tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL stall_early_done%0d got %b want 0", c, DONE); end
    end
    STALL = 1'b0;
    step();
    tests++; if (DONE !== 1'b1 || PC !== 5'd6) begin fails++; $display("FAIL stall_done got done=%b pc=%0d want 1 6", DONE, PC); end
  endtask

  task automatic test_len0();
    START = 1'b1; LEN = 6'd0;
    step();
    START = 1'b0;
    tests++; if (BUSY !== 1'b1 || VALID !== 1'b0 || DONE !== 1'b0) begin fails++; $display("FAIL len0_e0 got busy=%b valid=%b done=%b want 1 0 0", BUSY, VALID, DONE); end
    step();
    tests++; if (DONE !== 1'b1 || VALID !== 1'b0 || BUSY !== 1'b0 || PC !== 5'd0) begin fails++; $display("FAIL len0_done got done=%b valid=%b busy=%b pc=%0d want 1 0 0 0", DONE, VALID, BUSY, PC); end
    step();
    tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL len0_pulse got %b want 0", DONE); end
  endtask

  task automatic test_len40();
    int nvalid;
    nvalid = 0;
    START = 1'b1; LEN = 6'd40;
    step();
    START = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (VALID === 1'b1) nvalid++;
      tests++; if (VALID !== 1'b1 || INSTR !== fill_word(i) || PC !== 5'((i + 1) % 32)) begin fails++; $display("FAIL len40_w%0d got valid=%b instr=%h pc=%0d want 1 %h %0d", i, VALID, INSTR, PC, fill_word(i), (i + 1) % 32); end
    end
    step();
    tests++; if (DONE !== 1'b1 || VALID !== 1'b0 || PC !== 5'd0) begin fails++; $display("FAIL len40_done got done=%b valid=%b pc=%0d want 1 0 0", DONE, VALID, PC); end
    tests++; if (nvalid !== 32) begin fails++; $display("FAIL len40_count got %0d want 32", nvalid); end
  endtask

  task automatic test_locked();
    START = 1'b1; LEN = 6'd6;
    step();
    START = 1'b0;
    WE = 1'b1; WADDR = 5'd2; WDATA = 17'h1FFFF;
    for (int i = 0; i < 6; i++) begin
      START = (i == 1);
      LEN = (i == 1) ? 6'd3 : 6'd6;
      step();
      tests++; if (VALID !== 1'b1 || INSTR !== prog[i] || PC !== 5'(i + 1)) begin fails++; $display("FAIL locked_run_w%0d got valid=%b instr=%h pc=%0d want 1 %h %0d", i, VALID, INSTR, PC, prog[i], i + 1); end
    end
    START = 1'b0; WE = 1'b0;
    step();
    tests++; if (DONE !== 1'b1) begin fails++; $display("FAIL locked_done got %b want 1", DONE); end
    START = 1'b1; LEN = 6'd6;
    step();
    START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++; if (VALID !== 1'b1 || INSTR !== prog[i]) begin fails++; $display("FAIL locked_rerun_w%0d got valid=%b instr=%h want 1 %h", i, VALID, INSTR, prog[i]); end
    end
    step();
    tests++; if (DONE !== 1'b1) begin fails++; $display("FAIL locked_rerun_done got %b want 1", DONE); end
  endtask

  task automatic test_reset_mid();
    START = 1'b1; LEN = 6'd6;
    step();
    START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (VALID !== 1'b1 || INSTR !== prog[i]) begin fails++; $display("FAIL rstmid_w%0d got valid=%b instr=%h want 1 %h", i, VALID, INSTR, prog[i]); end
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    tests++; if (INSTR !== 17'h0 || VALID !== 1'b0 || BUSY !== 1'b0 || PC !== 5'd0 || DONE !== 1'b0) begin fails++; $display("FAIL rstmid_abort got instr=%h valid=%b busy=%b pc=%0d done=%b want 0 0 0 0 0", INSTR, VALID, BUSY, PC, DONE); end
    for (int c = 0; c < 5; c++) begin
      step();
      tests++; if (DONE !== 1'b0 || VALID !== 1'b0) begin fails++; $display("FAIL rstmid_quiet%0d got done=%b valid=%b want 0 0", c, DONE, VALID); end
    end
    START = 1'b1; LEN = 6'd6;
    step();
    START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++; if (VALID !== 1'b1 || INSTR !== prog[i]) begin fails++; $display("FAIL rstmid_replay_w%0d got valid=%b instr=%h want 1 %h", i, VALID, INSTR, prog[i]); end
    end
    step();
    tests++; if (DONE !== 1'b1 || PC !== 5'd6) begin fails++; $display("FAIL rstmid_replay_done got done=%b pc=%0d want 1 6", DONE, PC); end
  endtask

  task automatic test_back_to_back();
    START = 1'b1; LEN = 6'd1;
    step();
    START = 1'b0;
    step();
    tests++; if (VALID !== 1'b1 || INSTR !== prog[0]) begin fails++; $display("FAIL b2b_first got valid=%b instr=%h want 1 %h", VALID, INSTR, prog[0]); end
    step();
    tests++; if (DONE !== 1'b1) begin fails++; $display("FAIL b2b_done1 got %b want 1", DONE); end
    // Restart in the DONE cycle, with a write to address 0 on the same edge.
    START = 1'b1; LEN = 6'd2; WE = 1'b1; WADDR = 5'd0; WDATA = 17'h0ABCD;
    step();
    START = 1'b0; WE = 1'b0;
    tests++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin fails++; $display("FAIL b2b_restart got busy=%b done=%b want 1 0", BUSY, DONE); end
    step();
    tests++; if (VALID !== 1'b1 || INSTR !== 17'h0ABCD) begin fails++; $display("FAIL b2b_write_first got valid=%b instr=%h want 1 0abcd", VALID, INSTR); end
    step();
    tests++; if (VALID !== 1'b1 || INSTR !== prog[1]) begin fails++; $display("FAIL b2b_second got valid=%b instr=%h want 1 %h", VALID, INSTR, prog[1]); end
    step();
    tests++; if (DONE !== 1'b1 || PC !== 5'd2) begin fails++; $display("FAIL b2b_done2 got done=%b pc=%0d want 1 2", DONE, PC); end
  endtask

  initial begin
    prog[0] = 17'b10000110010000000;
    prog[1] = 17'b01001010000100010;
    prog[2] = 17'b10001100001000011;
    prog[3] = 17'b11000000011100100;
    prog[4] = 17'b11000000100000101;
    prog[5] = 17'b11000000100100110;
    test_reset();
    load_memory();
    test_stream();
    test_stall();
    test_len0();
    test_len40();
    test_locked();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
